// File: rtl/tree_pkg.sv
// Shared definitions for the tree_adder family: FSM state encoding, default
// geometry and the word-count width helper used by tree_input_packer.
package tree_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SIZE  = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Bits needed to hold a word count in 0..size inclusive.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/tree_input_packer.sv
// Packs a serial valid/ready word stream into SIZE-word frames for tree_adder;
// short frames (in_last) are zero-padded. Optional stats via TREE_PACKER_STATS_EN.
module tree_input_packer
  import tree_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int SIZE  = DEF_SIZE,
  localparam int CW    = cnt_width(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE*WIDTH-1:0] out_data,
  output logic [CW-1:0]         out_words
`ifdef TREE_PACKER_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           short_cnt
`endif
);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         words_q, words_d;
  logic [SIZE*WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         slot;
  logic                  accept;
  logic                  done;

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready = (state_q == FILL) || out_ready;
  assign accept   = in_valid && in_ready;

  // A word accepted while a frame is being released always opens a new frame.
  assign slot = (state_q == FULL) ? '0 : cnt_q;
  assign done = accept && ((slot == CW'(SIZE - 1)) || in_last);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    data_d  = data_q;

    if (accept) begin
      if (slot == '0) data_d = '0;
      data_d[int'(slot)*WIDTH +: WIDTH] = in_data;
    end

    if (done) begin
      state_d = FULL;
      words_d = slot + CW'(1);
      cnt_d   = '0;
    end else if (accept) begin
      state_d = FILL;
      cnt_d   = slot + CW'(1);
    end else if (state_q == FULL && out_ready) begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_words = words_q;

`ifdef TREE_PACKER_STATS_EN
  // Counts frames as they leave; both counters wrap naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      short_cnt <= '0;
    end else if (out_valid && out_ready) begin
      frame_cnt <= frame_cnt + 16'd1;
      if (words_q < CW'(SIZE)) short_cnt <= short_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tree_input_packer.sv
// Directed self-checking bench for tree_input_packer (WIDTH=8, SIZE=4).
module tb_tree_input_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_words;
`ifdef TREE_PACKER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] short_cnt;
`endif

  int total = 0;
  int bad   = 0;

  tree_input_packer #(.WIDTH(8), .SIZE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_words (out_words)
`ifdef TREE_PACKER_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .short_cnt (short_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input logic l);
    in_valid = 1'b1;
    in_data  = w;
    in_last  = l;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  logic [7:0]  w;
  logic [31:0] exp_frame;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    // 1 reset state
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data, 0);
    check("rst_words", out_words, 0);
    check("rst_ready", in_ready, 1);
`ifdef TREE_PACKER_STATS_EN
    check("rst_frame_cnt", frame_cnt, 0);
`endif
    step();

    // 2 full frame
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    check("full_not_yet", out_valid, 0);
    send(8'h04, 0);
    idle();
    check("full_valid", out_valid, 1);
    check("full_data",  out_data, 32'h04030201);
    check("full_words", out_words, 4);
    check("full_ready", in_ready, 1);
    step();
    check("full_one_cycle", out_valid, 0);

    // in_last without in_valid must not close a frame
    in_last = 1'b1;
    step();
    check("last_ignored", out_valid, 0);
    idle();

    // 3 short frame
    send(8'h0A, 0);
    send(8'h0B, 1);
    idle();
    check("short_valid", out_valid, 1);
    check("short_data",  out_data, 32'h00000B0A);
    check("short_words", out_words, 2);
    step();
    check("short_released", out_valid, 0);

    // 4 backpressure; frame also shows counter restarted at slot 0
    out_ready = 1'b0;
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data",  out_data, 32'h44332211);
      check("bp_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    check("bp_after_valid", out_valid, 0);
    check("bp_slot0_zerofill", out_data, 32'h00000055);
    send(8'h66, 0);
    send(8'h77, 0);
    send(8'h88, 0);
    check("bp_next_data", out_data, 32'h88776655);
    check("bp_next_valid", out_valid, 1);

    // 5 streaming: 16 words, no stalls, a frame after every 4th word
    exp_frame = 32'h0;
    for (int i = 1; i <= 16; i++) begin
      w = 8'h20 + 8'(i);
      in_valid = 1'b1; in_data = w; in_last = 1'b0;
      #1;
      check("stream_ready", in_ready, 1);
      exp_frame = {w, exp_frame[31:8]};
      step();
      check("stream_valid", out_valid, (i % 4) == 0);
      if ((i % 4) == 0) check("stream_data", out_data, exp_frame);
    end
    idle();
    step();
    check("stream_drained", out_valid, 0);

    // 6 mid-frame reset discards the partial frame
    send(8'hAA, 0);
    send(8'hBB, 0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data",  out_data, 0);
    step();
    rst = 1'b0;
    send(8'hC1, 0);
    send(8'hC2, 0);
    check("mid_no_stale2", out_valid, 0);
    send(8'hC3, 0);
    check("mid_no_stale3", out_valid, 0);
    send(8'hC4, 1);
    idle();
    check("mid_valid", out_valid, 1);
    check("mid_data",  out_data, 32'hC4C3C2C1);
    check("mid_words", out_words, 4);
    step();
    check("mid_released", out_valid, 0);
`ifdef TREE_PACKER_STATS_EN
    check("mid_frame_cnt", frame_cnt, 1);
    check("mid_short_cnt", short_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
